// File: rtl/blwe_pkg.sv
// Shared types and constants for the BLWE noise sampler.
// Holds default sizes, LFSR constants and the sampler state encoding.
package blwe_pkg;

    localparam int N_DEFAULT = 4;
    localparam int Q_DEFAULT = 2;

    localparam int              LFSR_W            = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2
    } state_t;

    // A zero seed would lock the LFSR, so it maps to the default seed.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/blwe_lfsr16.sv
// 16-bit right-shifting Galois LFSR used as the noise bit source.
// rnd_bit is the low bit consumed by the current step.
module blwe_lfsr16
    import blwe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic              rnd_bit
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr <= fix_seed(seed);
        end else if (step) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

    assign rnd_bit = lfsr[0];

endmodule

// File: rtl/blwe_noise_sampler.sv
// Fills one bundle of binary noise polynomials/scalars from the LFSR,
// one bit per cycle, then presents it with a valid/ready handshake.
module blwe_noise_sampler
    import blwe_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int Q = Q_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_load,
    input  logic [15:0]         seed,
    input  logic                req,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][Q-1:0] r1,
    output logic [N-1:0][Q-1:0] e2,
    output logic [N-1:0][Q-1:0] e3,
    output logic [Q-1:0]        r2,
    output logic [Q-1:0]        e1
);

    localparam int CW = $clog2(3*N+2);
    localparam logic [CW-1:0] LAST = CW'(3*N+1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          load, step, rnd_bit;
    logic [Q-1:0]  coef;

    blwe_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .seed    (seed),
        .rnd_bit (rnd_bit)
    );

    assign load = (state == IDLE) && seed_load;
    assign step = (state == FILL);
    assign coef = Q'(rnd_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!seed_load && req) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (cnt == LAST) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_next = req ? FILL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt idles at zero, so every entry into FILL starts at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == FILL && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= '0;
            e2 <= '0;
            e3 <= '0;
            r2 <= '0;
            e1 <= '0;
        end else if (state == FILL) begin
            for (int k = 0; k < N; k++) begin
                if (cnt == CW'(k))       r1[k] <= coef;
                if (cnt == CW'(N + k))   e2[k] <= coef;
                if (cnt == CW'(2*N + k)) e3[k] <= coef;
            end
            if (cnt == CW'(3*N)) r2 <= coef;
            if (cnt == LAST)     e1 <= coef;
        end
    end

    assign busy      = (state == FILL);
    assign out_valid = (state == VALID);

endmodule

// File: doc/blwe_noise_sampler.md
BLWE_NOISE_SAMPLER -- requirements
Module: blwe_noise_sampler

Interface
REQ-001 The block SHALL have parameter N, default 4, polynomial length (coefficient count).
REQ-002 The block SHALL have parameter Q, default 2, coefficient width in bits; sampled coefficients are binary, 0 or 1, zero-extended to Q bits.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- seed_load  in  1  load seed into LFSR.
- seed  in  16  LFSR seed value.
- req  in  1  request one noise bundle.
- busy  out  1  high while sampling.
- out_valid  out  1  bundle available.
- out_ready  in  1  consumer accepts bundle.
- r1, e2, e3  out  [N-1:0][Q-1:0]  binary polynomials for the RingLWE core.
- r2, e1  out  Q  binary scalars for the RingLWE core.

Function
REQ-004 The block SHALL implement FSM states IDLE, FILL and VALID.
REQ-005 LFSR SHALL be 16-bit Galois, right-shift, tap mask 16'hB400; per step: bit = lfsr[0], lfsr <= (lfsr>>1) ^ (bit ? 16'hB400 : 0).
REQ-006 In IDLE with seed_load=1, lfsr SHALL load seed, or 16'hACE1 if seed==0; seed_load SHALL be ignored in FILL and VALID.
REQ-007 IDLE with req=1 SHALL go to FILL with cnt=0; seed_load takes priority over req in the same cycle, so the request is not accepted that cycle.
REQ-008 Each FILL cycle SHALL step the LFSR once and write bit k=cnt: k<N -> r1[k]; N..2N-1 -> e2[k-N]; 2N..3N-1 -> e3[k-2N]; 3N -> r2; 3N+1 -> e1.
REQ-009 After writing k=3N+1, state SHALL go to VALID; FILL SHALL last exactly 3N+2 cycles (14 for N=4); out_valid SHALL rise on the edge that writes the last bit.
REQ-010 busy SHALL equal (state==FILL); out_valid SHALL equal (state==VALID).
REQ-011 Outputs r1, e2, e3, r2, e1 SHALL change only during FILL and SHALL hold stable throughout VALID.
REQ-012 In VALID, out_ready=1 SHALL complete the handshake.
- req=0 that cycle: next state IDLE.
- req=1 that cycle: next state FILL with cnt=0 (back-to-back).
REQ-013 req SHALL be ignored in FILL and in VALID without out_ready.
REQ-014 The LFSR state SHALL persist across bundles; it SHALL NOT be reseeded per request.
REQ-015 cnt SHALL be sized $clog2(3N+2) and SHALL never exceed 3N+1.

Reset
REQ-016 rst SHALL set state=IDLE, cnt=0, lfsr=16'hACE1, busy=0, out_valid=0, and all coefficient outputs to 0.
REQ-017 rst SHALL take priority over every input; rst asserted mid-FILL or in VALID SHALL discard the partial or pending bundle.

Structure
REQ-018 Shared package blwe_pkg SHALL hold:
- N and Q defaults.
- LFSR_W=16, LFSR_TAPS=16'hB400, LFSR_DEFAULT_SEED=16'hACE1.
- the sampler state enum.
REQ-019 The LFSR SHALL be one sub-module, blwe_lfsr16, with load, step, and seed ports and a bit output; the FSM, counter and coefficient registers SHALL stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- rst, seed_load seed=16'h0001, req pulse -> busy for 14 cycles, then out_valid; r1={0,0,0,1} (r1[0]=1), e2=0, e3 with only e3[3]=1, r2=0, e1=1; internal lfsr=16'h9905.
- seed_load seed=0 -> lfsr=16'hACE1; bundle identical to the one produced after a reset.
- Hold out_ready=0 for 20 cycles in VALID -> outputs and out_valid stable; req pulses ignored.
- out_ready=1 and req=1 in the same VALID cycle -> next cycle busy=1; second bundle continues from lfsr=16'h9905.
- rst at FILL cycle 7 -> next cycle all outputs 0, IDLE; a new req gives the same bundle as the first scenario only after reseeding with 16'h0001.
- seed_load and req together in IDLE -> seed loaded, request not accepted; busy stays 0.
